// File: rtl/ahb_gpio_param_if.sv
// ahb_gpio_param_if: AHB-Lite slave bus bundle for the parametrised GPIO peripheral.
`default_nettype none

interface ahb_gpio_param_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA
    );
endinterface

`default_nettype wire

// File: rtl/ahb_gpio_param.sv
// ahb_gpio_param: zero-wait AHB-Lite GPIO with direction, parity and input sync.
// Define GPIO_IRQ_EN to build the per-bit rising-edge interrupt logic.
`default_nettype none

module ahb_gpio_param #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    ahb_gpio_param_if.slave        bus,
    input  wire logic [DATA_W:0]   GPIOIN,
    input  wire logic              PARITYSEL,
    output logic      [DATA_W:0]   GPIOOUT,
    output logic      [DATA_W-1:0] GPIODIR,
    output logic                   PARITYERR,
    output logic                   IRQ
);
    localparam int c_OW = ADDR_W - 2;
    localparam logic [c_OW-1:0] c_OFF_DATA  = c_OW'(0);
    localparam logic [c_OW-1:0] c_OFF_DIR   = c_OW'(1);
    localparam logic [c_OW-1:0] c_OFF_PSTAT = c_OW'(4);

    logic              r_dp_write;
    logic [c_OW-1:0]   r_dp_addr;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_dir;
    logic [DATA_W:0]   r_sync [SYNC_STAGES];
    logic              r_perr;
    logic              r_sticky;

    logic              w_aphase;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W:0]   w_sync_in;
    logic [DATA_W-1:0] w_drive;
    logic              w_perr_nxt;
    logic [31:0]       w_rdata;
    logic              w_unused_ok;

    assign w_aphase   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign w_we       = r_dp_write;
    assign w_wdata    = bus.HWDATA[DATA_W-1:0];
    assign w_sync_in  = r_sync[SYNC_STAGES-1];
    assign w_drive    = r_out & r_dir;
    assign w_perr_nxt = (^w_sync_in) ^ PARITYSEL;

    assign GPIOOUT       = {(^w_drive) ^ PARITYSEL, w_drive};
    assign GPIODIR       = r_dir;
    assign PARITYERR     = r_perr;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRDATA    = w_rdata;
    assign w_unused_ok   = ^{bus.HTRANS[0], bus.HADDR[1:0], bus.HADDR[31:ADDR_W],
                             bus.HWDATA[31:DATA_W]};

    // Only a write's data phase needs remembering; reads decode r_dp_addr directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
        end else begin
            r_dp_write <= w_aphase & bus.HWRITE;
            if (w_aphase) begin
                r_dp_addr <= bus.HADDR[ADDR_W-1:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_dir <= '0;
        end else begin
            if (w_we && r_dp_addr == c_OFF_DATA) r_out <= w_wdata;
            if (w_we && r_dp_addr == c_OFF_DIR)  r_dir <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= GPIOIN;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // A fresh parity error outranks a simultaneous sticky-clear write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr   <= 1'b0;
            r_sticky <= 1'b0;
        end else begin
            r_perr   <= w_perr_nxt;
            r_sticky <= w_perr_nxt | (r_sticky & ~(w_we && r_dp_addr == c_OFF_PSTAT));
        end
    end

`ifdef GPIO_IRQ_EN
    localparam logic [c_OW-1:0] c_OFF_IEN  = c_OW'(2);
    localparam logic [c_OW-1:0] c_OFF_ISTA = c_OW'(3);

    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_irq_en;
    logic [DATA_W-1:0] r_irq_stat;
    logic              r_irq;
    logic [DATA_W-1:0] w_rise;
    logic [DATA_W-1:0] w_w1c;

    assign w_rise = w_sync_in[DATA_W-1:0] & ~r_prev & ~r_dir;
    assign w_w1c  = (w_we && r_dp_addr == c_OFF_ISTA) ? w_wdata : '0;
    assign IRQ    = r_irq;

    // New edges are OR-ed in after the clear so a coincident rise is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_sync_in[DATA_W-1:0];
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_rise;
            r_irq      <= |(r_irq_stat & r_irq_en);
            if (w_we && r_dp_addr == c_OFF_IEN) r_irq_en <= w_wdata;
        end
    end
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        w_rdata = 32'd0;
        case (r_dp_addr)
            c_OFF_DATA:  w_rdata[DATA_W-1:0] = w_drive | (w_sync_in[DATA_W-1:0] & ~r_dir);
            c_OFF_DIR:   w_rdata[DATA_W-1:0] = r_dir;
`ifdef GPIO_IRQ_EN
            c_OFF_IEN:   w_rdata[DATA_W-1:0] = r_irq_en;
            c_OFF_ISTA:  w_rdata[DATA_W-1:0] = r_irq_stat;
`endif
            c_OFF_PSTAT: w_rdata[1:0]        = {r_sticky, r_perr};
            default:     w_rdata             = 32'd0;
        endcase
    end
endmodule

`default_nettype wire

// File: tb/tb_ahb_gpio_param.sv
// tb_ahb_gpio_param: directed + random bus/pad stimulus against a cycle-level register model.
`default_nettype none

module tb_ahb_gpio_param;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_gpio_param_if bus ();
    logic [DW:0]   gpioin;
    logic          psel;
    logic [DW:0]   gpioout;
    logic [DW-1:0] gpiodir;
    logic          perr;
    logic          irq;

    ahb_gpio_param #(.DATA_W(DW), .SYNC_STAGES(SS), .ADDR_W(AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .GPIOIN    (gpioin),
        .PARITYSEL (psel),
        .GPIOOUT   (gpioout),
        .GPIODIR   (gpiodir),
        .PARITYERR (perr),
        .IRQ       (irq)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_out, m_dir, m_en, m_stat, m_prev;
    logic          m_perr, m_sticky, m_irq;
    logic [DW:0]   m_hist[$];
    logic          m_pv, m_pw;
    logic [31:0]   m_pa;

    logic [31:0] g_wdata = 32'd0;
    logic [DW:0] g_pin = '0;
    logic        g_psel = 1'b0;
    logic        g_hready = 1'b1;
    logic [31:0] g_rdata = 32'd0;

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_stat = '0; m_prev = '0;
        m_perr = 1'b0; m_sticky = 1'b0; m_irq = 1'b0;
        m_pv = 1'b0; m_pw = 1'b0; m_pa = 32'd0;
        m_hist = {};
        for (int i = 0; i < SS; i++) m_hist.push_back('0);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        logic [DW:0] s;
        int off;
        r = 32'd0;
        s = m_hist[0];
        off = int'(a[AW-1:2]);
        case (off)
            0: r[DW-1:0] = (m_out & m_dir) | (s[DW-1:0] & ~m_dir);
            1: r[DW-1:0] = m_dir;
`ifdef GPIO_IRQ_EN
            2: r[DW-1:0] = m_en;
            3: r[DW-1:0] = m_stat;
`endif
            4: r[1:0] = {m_sticky, m_perr};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One bus cycle: drive, check current outputs, advance model across the edge.
    task automatic step(input logic sel, input logic [1:0] tr, input logic wr, input logic [31:0] a);
        logic [DW:0]   s;
        logic [DW-1:0] w, rise, n_out, n_dir, n_en, n_stat;
        logic          n_perr, n_sticky, n_irq, n_pv;
        int            off;
        bus.HSEL = sel; bus.HTRANS = tr; bus.HWRITE = wr; bus.HADDR = a;
        bus.HWDATA = g_wdata; bus.HREADY = g_hready;
        gpioin = g_pin; psel = g_psel;
        #1;
        chk("GPIODIR", 32'(gpiodir), 32'(m_dir));
        chk("GPIOOUT", 32'(gpioout), 32'({(^(m_out & m_dir)) ^ g_psel, m_out & m_dir}));
        chk("PARITYERR", 32'(perr), 32'(m_perr));
        chk("IRQ", 32'(irq), 32'(m_irq));
        chk("HREADYOUT", 32'(bus.HREADYOUT), 32'd1);
        if (m_pv && !m_pw) begin
            g_rdata = bus.HRDATA;
            chk("HRDATA", bus.HRDATA, m_read(m_pa));
        end
        s = m_hist[0];
        w = g_wdata[DW-1:0];
        off = int'(m_pa[AW-1:2]);
        n_perr = (^s) ^ g_psel;
        n_sticky = m_sticky | n_perr;
        n_out = m_out; n_dir = m_dir; n_en = m_en; n_stat = m_stat; n_irq = 1'b0;
        rise = '0;
`ifdef GPIO_IRQ_EN
        rise = s[DW-1:0] & ~m_prev & ~m_dir;
        n_stat = m_stat | rise;
        n_irq = |(m_stat & m_en);
`endif
        if (m_pv && m_pw) begin
            case (off)
                0: n_out = w;
                1: n_dir = w;
`ifdef GPIO_IRQ_EN
                2: n_en = w;
                3: n_stat = (m_stat & ~w) | rise;
`endif
                4: n_sticky = n_perr;
                default: ;
            endcase
        end
        n_pv = sel & g_hready & tr[1];
        @(posedge clk);
        #1;
        m_out = n_out; m_dir = n_dir; m_en = n_en; m_stat = n_stat; m_irq = n_irq;
        m_perr = n_perr; m_sticky = n_sticky;
        m_prev = s[DW-1:0];
        m_hist.push_back(g_pin);
        void'(m_hist.pop_front());
        if (n_pv) m_pa = a;
        m_pv = n_pv;
        m_pw = n_pv & wr;
    endtask

    task automatic xfer_raw(input logic sel, input logic [1:0] tr, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        step(sel, tr, wr, a);
        g_wdata = d;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        xfer_raw(1'b1, 2'b10, wr, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) xfer_raw(1'b0, 2'b00, 1'b0, 32'd0, $urandom);
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(1'b0, a, $urandom);
        idle(1);
    endtask

    initial begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'd0;
        bus.HWDATA = 32'd0; bus.HREADY = 1'b1;
        gpioin = '0; psel = 1'b0;
        model_reset();

        // Reset state
        @(posedge clk);
        #3;
        chk("rst_GPIOOUT", 32'(gpioout), 32'h0);
        chk("rst_GPIODIR", 32'(gpiodir), 32'h0);
        chk("rst_IRQ", 32'(irq), 32'h0);
        chk("rst_HRDATA", bus.HRDATA, 32'h0);
        chk("rst_HREADYOUT", 32'(bus.HREADYOUT), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd(32'(i * 4));
            chk("rst_read", g_rdata, 32'h0);
        end
        g_psel = 1'b1;
        idle(1);
        chk("rst_parity_odd", 32'(gpioout), 32'h10000);

        // Direction and data output
        g_psel = 1'b0;
        xfer(1'b1, 32'h04, 32'h00FF);
        xfer(1'b1, 32'h00, 32'hA5A5);
        xfer(1'b0, 32'h00, 32'd0);
        idle(1);
        chk("b2b_read_data", g_rdata, 32'h000000A5);
        chk("out_A5", 32'(gpioout), 32'h000A5);
        chk("dir_FF", 32'(gpiodir), 32'h00FF);

        // Input synchronisation and parity checking
        xfer(1'b1, 32'h04, 32'h0);
        idle(1);
        g_pin = 17'h10001;
        idle(3);
        chk("perr_good", 32'(perr), 32'h0);
        rd(32'h00);
        chk("sync_data", g_rdata, 32'h1);
        g_pin = 17'h00001;
        idle(3);
        chk("perr_bad", 32'(perr), 32'h1);
        rd(32'h10);
        chk("pstat_3", g_rdata, 32'h3);
        g_pin = 17'h10001;
        idle(4);
        rd(32'h10);
        chk("pstat_2", g_rdata, 32'h2);
        xfer(1'b1, 32'h10, 32'h0);
        idle(1);
        rd(32'h10);
        chk("pstat_clr", g_rdata, 32'h0);

`ifdef GPIO_IRQ_EN
        // Rising-edge interrupts
        g_pin = 17'h00000;
        idle(4);
        xfer(1'b1, 32'h0C, 32'hFFFF);
        xfer(1'b1, 32'h08, 32'h0001);
        idle(2);
        chk("irq_idle", 32'(irq), 32'h0);
        g_pin = 17'h10001;
        idle(4);
        rd(32'h0C);
        chk("irq_stat_set", g_rdata, 32'h1);
        chk("irq_high", 32'(irq), 32'h1);
        xfer(1'b1, 32'h0C, 32'h0001);
        idle(2);
        chk("irq_cleared", 32'(irq), 32'h0);
        g_pin = 17'h00000;
        idle(4);
        g_pin = 17'h10001;
        idle(1);
        xfer(1'b1, 32'h0C, 32'h0001);
        idle(1);
        rd(32'h0C);
        chk("w1c_vs_rise", g_rdata, 32'h1);
        xfer(1'b1, 32'h08, 32'h0);
        idle(1);
`endif

        // Non-valid transfers must not write
        xfer(1'b1, 32'h04, 32'hFFFF);
        xfer_raw(1'b1, 2'b00, 1'b1, 32'h00, 32'hFFFF);
        idle(1);
        xfer_raw(1'b0, 2'b10, 1'b1, 32'h00, 32'hFFFF);
        idle(1);
        chk("no_write_idle", 32'(gpioout[DW-1:0]), 32'hA5A5);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[AW-1:2] = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) g_pin = (DW+1)'($urandom);
            if ($urandom_range(0, 15) == 0) g_psel = ~g_psel;
            g_hready = ($urandom_range(0, 7) != 0);
            xfer_raw(($urandom_range(0, 5) != 0), 2'($urandom), 1'($urandom), a, $urandom);
        end
        g_hready = 1'b1;

        // Reset during a write data phase
        xfer(1'b1, 32'h04, 32'h00F0);
        idle(1);
        xfer(1'b1, 32'h04, 32'hFFFF);
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = g_wdata;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_now", 32'(gpiodir), 32'h0);
        @(posedge clk);
        #2;
        chk("rst_mid_held", 32'(gpiodir), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("rst_mid_after", 32'(gpiodir), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
